// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - fixed-priority SRAM arbiter with port 1 starvation guard
// Read data is steered back by a tag pipeline matched to the SRAM read latency.
module imem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_en,
  input  logic                  p0_we,
  input  logic [ADDR_W-1:0]     p0_addr,
  input  logic [DATA_W-1:0]     p0_data_w,
  input  logic [DATA_W/8-1:0]   p0_be,
  output logic                  p0_gnt,
  output logic [DATA_W-1:0]     p0_data_r,
  output logic                  p0_valid,
  input  logic                  p1_en,
  input  logic                  p1_we,
  input  logic [ADDR_W-1:0]     p1_addr,
  input  logic [DATA_W-1:0]     p1_data_w,
  input  logic [DATA_W/8-1:0]   p1_be,
  output logic                  p1_gnt,
  output logic [DATA_W-1:0]     p1_data_r,
  output logic                  p1_valid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_data_w,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_data_r
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  wait_cnt;
  logic              force_p1;
  logic              sel0;
  logic              sel1;
  logic              push_vld;
  logic              push_id;
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_id;

  // Port 1 wins when port 0 is quiet or when it has waited MAX_WAIT cycles.
  assign force_p1 = (wait_cnt == WAIT_MAX);
  assign sel1     = reset && p1_en && (force_p1 || !p0_en);
  assign sel0     = reset && p0_en && !sel1;
  assign p0_gnt   = sel0;
  assign p1_gnt   = sel1;

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_data_w = '0;
    mem_be     = '0;
    if (sel1) begin
      mem_en     = 1'b1;
      mem_we     = p1_we;
      mem_addr   = p1_addr;
      mem_data_w = p1_data_w;
      mem_be     = p1_be;
    end else if (sel0) begin
      mem_en     = 1'b1;
      mem_we     = p0_we;
      mem_addr   = p0_addr;
      mem_data_w = p0_data_w;
      mem_be     = p0_be;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (sel1 || !p1_en) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign push_vld = (sel0 || sel1) && !mem_we;
  assign push_id  = sel1 && !p1_we;

  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        tag_vld <= '0;
        tag_id  <= '0;
      end else begin
        tag_vld <= push_vld;
        tag_id  <= push_id;
      end
    end
  end else begin : g_latn
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        tag_vld <= '0;
        tag_id  <= '0;
      end else begin
        tag_vld <= {tag_vld[RD_LAT-2:0], push_vld};
        tag_id  <= {tag_id[RD_LAT-2:0], push_id};
      end
    end
  end

  assign p0_valid  = tag_vld[RD_LAT-1] && !tag_id[RD_LAT-1];
  assign p1_valid  = tag_vld[RD_LAT-1] && tag_id[RD_LAT-1];
  assign p0_data_r = mem_data_r;
  assign p1_data_r = mem_data_r;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - scoreboard bench for imem_arbiter at RD_LAT 1, 2 and 3
module tb_imem_arbiter;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        p0_en, p0_we, p1_en, p1_we;
  logic [11:0] p0_addr, p1_addr;
  logic [31:0] p0_data_w, p1_data_w;
  logic [3:0]  p0_be, p1_be;

  logic        g0 [3];
  logic        g1 [3];
  logic        v0 [3];
  logic        v1 [3];
  logic [31:0] rd0 [3];
  logic [31:0] rd1 [3];
  logic        men [3];
  logic        mwe [3];
  logic [11:0] maddr [3];
  logic [31:0] mdw [3];
  logic [3:0]  mbe [3];
  logic [31:0] mdr [3];

  logic [31:0] sram [4096];
  logic [31:0] rp [3][3];
  exp_t        sbq [3][$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    imem_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(k + 1), .MAX_WAIT(4)) u_dut (
      .clk(clk), .reset(reset),
      .p0_en(p0_en), .p0_we(p0_we), .p0_addr(p0_addr), .p0_data_w(p0_data_w), .p0_be(p0_be),
      .p0_gnt(g0[k]), .p0_data_r(rd0[k]), .p0_valid(v0[k]),
      .p1_en(p1_en), .p1_we(p1_we), .p1_addr(p1_addr), .p1_data_w(p1_data_w), .p1_be(p1_be),
      .p1_gnt(g1[k]), .p1_data_r(rd1[k]), .p1_valid(v1[k]),
      .mem_en(men[k]), .mem_we(mwe[k]), .mem_addr(maddr[k]), .mem_data_w(mdw[k]),
      .mem_be(mbe[k]), .mem_data_r(mdr[k])
    );
    assign mdr[k] = rp[k][k];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: preloaded while reset is low, read data delayed by each instance's latency.
  always @(posedge clk) begin
    if (!reset) begin
      sram[12'h010] <= 32'hDEAD_BEEF;
      sram[12'h011] <= 32'h1111_1111;
      sram[12'h020] <= 32'h1234_5678;
      sram[12'h001] <= 32'h0000_0A01;
      sram[12'h002] <= 32'h0000_0B02;
      sram[12'h003] <= 32'h0000_0C03;
      for (int k = 0; k < 3; k++)
        for (int s = 0; s < 3; s++) rp[k][s] <= 32'h0;
    end else begin
      if (men[0] && mwe[0])
        for (int b = 0; b < 4; b++)
          if (mbe[0][b]) sram[maddr[0]][8*b +: 8] <= mdw[0][8*b +: 8];
      for (int k = 0; k < 3; k++) begin
        rp[k][0] <= (men[0] && !mwe[0]) ? sram[maddr[0]] : 32'h0BAD_0BAD;
        rp[k][1] <= rp[k][0];
        rp[k][2] <= rp[k][1];
      end
    end
  end

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic drv(input logic e0, input logic w0, input logic [11:0] a0, input logic [31:0] d0,
                     input logic [3:0] b0, input logic e1, input logic w1, input logic [11:0] a1,
                     input logic [31:0] d1, input logic [3:0] b1);
    p0_en = e0; p0_we = w0; p0_addr = a0; p0_data_w = d0; p0_be = b0;
    p1_en = e1; p1_we = w1; p1_addr = a1; p1_data_w = d1; p1_be = b1;
  endtask

  task automatic idle();
    drv(0, 0, 12'h0, 32'h0, 4'h0, 0, 0, 12'h0, 32'h0, 4'h0);
  endtask

  // One cycle: check expected grants and the SRAM-side mux, record expected read return.
  task automatic step(input logic x0, input logic x1, input logic [31:0] xrd, input bit push,
                      input string nm);
    logic        ewe;
    logic [11:0] ea;
    logic [31:0] ed;
    logic [3:0]  eb;
    ewe = x1 ? p1_we     : (x0 ? p0_we     : 1'b0);
    ea  = x1 ? p1_addr   : (x0 ? p0_addr   : 12'h0);
    ed  = x1 ? p1_data_w : (x0 ? p0_data_w : 32'h0);
    eb  = x1 ? p1_be     : (x0 ? p0_be     : 4'h0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_p0_gnt[%0d]", nm, k), g0[k], x0);
      chk($sformatf("%s_p1_gnt[%0d]", nm, k), g1[k], x1);
      chk($sformatf("%s_mem_en[%0d]", nm, k), men[k], x0 | x1);
      chk($sformatf("%s_mem_we[%0d]", nm, k), mwe[k], ewe);
      chk($sformatf("%s_mem_addr[%0d]", nm, k), maddr[k], ea);
      chk($sformatf("%s_mem_data_w[%0d]", nm, k), mdw[k], ed);
      chk($sformatf("%s_mem_be[%0d]", nm, k), mbe[k], eb);
      if (push && (x0 || x1) && !ewe) sbq[k].push_back('{x1, xrd, cyc + k + 1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_cycle(input string nm);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_valid[%0d]", nm, k), {v1[k], v0[k]}, 2'b00);
      chk($sformatf("%s_gnt[%0d]", nm, k), {g1[k], g0[k], men[k]}, 3'b000);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          for (int k = 0; k < 3; k++) begin
            if (v0[k] || v1[k]) begin
              if (sbq[k].size() == 0) begin
                chk($sformatf("spurious_valid[%0d]", k), {v1[k], v0[k]}, 2'b00);
              end else begin
                e = sbq[k].pop_front();
                chk($sformatf("valid_port[%0d]", k), {v1[k], v0[k]}, e.id ? 2'b10 : 2'b01);
                chk($sformatf("rdata[%0d]", k), v1[k] ? rd1[k] : rd0[k], e.data);
                chk($sformatf("latency[%0d]", k), cyc, e.cyc);
              end
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    // Reset held with both ports requesting: nothing may be granted.
    drv(1, 0, 12'h010, 32'h0, 4'hF, 1, 0, 12'h011, 32'h0, 4'hF);
    repeat (3) quiet_cycle("reset");
    reset = 1'b1;

    // Both ports read continuously: p0 four times, then p1 forced once.
    for (int i = 0; i < 10; i++)
      step(i % 5 != 4, i % 5 == 4, (i % 5 == 4) ? 32'h1111_1111 : 32'hDEAD_BEEF, 1'b1, "arb");
    idle();
    step(0, 0, 32'h0, 1'b1, "idle");

    drv(1, 0, 12'h010, 32'h0, 4'hF, 0, 0, 12'h0, 32'h0, 4'h0);
    step(1, 0, 32'hDEAD_BEEF, 1'b1, "p0_read");
    idle();
    step(0, 0, 32'h0, 1'b1, "idle2");

    drv(0, 0, 12'h0, 32'h0, 4'h0, 1, 1, 12'h020, 32'h0000_00AA, 4'b0001);
    step(0, 1, 32'h0, 1'b1, "p1_write");
    idle();
    repeat (3) step(0, 0, 32'h0, 1'b1, "post_write");
    drv(1, 0, 12'h020, 32'h0, 4'hF, 0, 0, 12'h0, 32'h0, 4'h0);
    step(1, 0, 32'h1234_56AA, 1'b1, "readback");

    drv(1, 0, 12'h001, 32'h0, 4'hF, 0, 0, 12'h0, 32'h0, 4'h0);
    step(1, 0, 32'h0000_0A01, 1'b1, "il_p0a");
    drv(0, 0, 12'h0, 32'h0, 4'h0, 1, 0, 12'h002, 32'h0, 4'hF);
    step(0, 1, 32'h0000_0B02, 1'b1, "il_p1");
    drv(1, 0, 12'h003, 32'h0, 4'hF, 0, 0, 12'h0, 32'h0, 4'h0);
    step(1, 0, 32'h0000_0C03, 1'b1, "il_p0b");
    idle();
    repeat (4) step(0, 0, 32'h0, 1'b1, "drain");

    // p1 read granted, then reset one cycle later: its return must be dropped.
    drv(0, 0, 12'h0, 32'h0, 4'h0, 1, 0, 12'h011, 32'h0, 4'hF);
    step(0, 1, 32'h1111_1111, 1'b0, "p1_flight");
    reset = 1'b0;
    idle();
    repeat (2) quiet_cycle("flight_rst");
    reset = 1'b1;
    repeat (3) quiet_cycle("flight_post");

    for (int k = 0; k < 3; k++)
      chk($sformatf("pending[%0d]", k), sbq[k].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
